// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - byte-serial responder for cache-to-memory requests
//
// Turns one 1/2/4-byte load or store into consecutive byte cycles on a
// byte-wide RAM/IO bus. Load results are assembled little-endian and then
// sign- or zero-extended. Stores into the IO region wait while the IO
// buffer is full.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   rdy            global enable; low freezes all state and idles the bus
//   clear          synchronous abort of any in-flight request
//   valid/wr/addr/len/data   request (len[1:0] size, len[2] zero-extend)
//   ready/res      one-cycle completion pulse and load result
//   mem_din        RAM read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr    byte write data, byte address, write strobe
//   io_buffer_full IO output buffer full, sampled per written byte

module mem_byte_sequencer #(
  parameter logic [31:0] IO_BASE = 32'h00030000,
  parameter int          BYTE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              valid,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [2:0]        len,
  input  logic [31:0]       data,
  output logic              ready,
  output logic [31:0]       res,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [2:0]  n;       // request size in bytes: 1, 2 or 4
  logic        sext;
  logic [31:0] wdata;
  logic [2:0]  idx;
  logic [31:0] rbuf;

  logic [31:0] cur_a;
  logic        wr_stall;
  logic        active;
  logic [31:0] res_ext;

  assign cur_a    = base + {29'd0, idx};
  assign wr_stall = (cur_a[17:16] == IO_BASE[17:16]) && io_buffer_full;
  // Outputs are idle whenever the sequencer is frozen or being aborted.
  assign active   = rdy && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      base  <= 32'd0;
      n     <= 3'd1;
      sext  <= 1'b0;
      wdata <= 32'd0;
      idx   <= 3'd0;
      rbuf  <= 32'd0;
    end else if (clear) begin
      state <= S_IDLE;
      idx   <= 3'd0;
      rbuf  <= 32'd0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            base  <= addr;
            n     <= len[1] ? 3'd4 : (len[0] ? 3'd2 : 3'd1);
            sext  <= ~len[2];
            wdata <= data;
            idx   <= 3'd0;
            // Cleared so a store completes with an all-zero result.
            rbuf  <= 32'd0;
            state <= wr ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          // mem_din holds the byte addressed one cycle earlier (idx-1).
          for (int i = 0; i < 4; i++) begin
            if (idx == 3'(i + 1)) begin
              rbuf[i*BYTE_W +: BYTE_W] <= mem_din;
            end
          end
          if (idx == n) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_WRITE: begin
          if (!wr_stall) begin
            idx <= idx + 3'd1;
            if (idx == n - 3'd1) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (n)
      3'd1:    res_ext = {{24{sext & rbuf[7]}}, rbuf[7:0]};
      3'd2:    res_ext = {{16{sext & rbuf[15]}}, rbuf[15:0]};
      default: res_ext = rbuf;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    res      = 32'd0;
    mem_a    = 32'd0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (active) begin
      case (state)
        S_READ: begin
          if (idx < n) begin
            mem_a = cur_a;
          end
        end
        S_WRITE: begin
          mem_a    = cur_a;
          mem_dout = wdata[{idx[1:0], 3'b000} +: BYTE_W];
          mem_wr   = !wr_stall;
        end
        S_DONE: begin
          ready = 1'b1;
          res   = res_ext;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - scoreboard bench for mem_byte_sequencer

module tb_mem_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [2:0]  len = 3'd0;
  logic [31:0] data = 32'd0;
  logic        ready;
  logic [31:0] res;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_byte_sequencer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .valid(valid), .wr(wr), .addr(addr), .len(len), .data(data),
    .ready(ready), .res(res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; int c0; int lat; } rsp_t;
  typedef struct { int cyc; logic [31:0] a; } rd_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wrx_t;

  rsp_t exp_rsp[$];
  rd_t  exp_rd[$];
  wrx_t exp_wr[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int resp_cnt = 0;

  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Registered RAM: shares the global enable, so its output holds while rdy is low.
  always @(posedge clk) begin
    if (rdy) mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  // Monitor: pops expectations whenever the DUT presents bus activity or a response.
  always @(negedge clk) begin : monitor
    int i;
    rsp_t r;
    wrx_t x;
    if (rst) begin
      i = 0;
      while (i < exp_rd.size()) begin
        if (exp_rd[i].cyc == cyc) begin
          chk("rd_addr", mem_a, exp_rd[i].a);
          chk("rd_nowr", {31'd0, mem_wr}, 32'd0);
          exp_rd.delete(i);
        end else begin
          i++;
        end
      end
      if (mem_wr) begin
        chk("io_stall", {31'd0, mem_a[17:16] == 2'b11 && io_buffer_full}, 32'd0);
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", mem_a, 32'hxxxxxxxx);
        end else begin
          x = exp_wr.pop_front();
          chk("wr_addr", mem_a, x.a);
          chk("wr_data", {24'd0, mem_dout}, {24'd0, x.d});
        end
      end
      if (ready) begin
        resp_cnt++;
        if (exp_rsp.size() == 0) begin
          chk("unexpected_ready", res, 32'hxxxxxxxx);
        end else begin
          r = exp_rsp.pop_front();
          chk("res", res, r.res);
          chk("latency", cyc - r.c0, r.lat);
        end
      end
    end
  end

  // One request: model expectations are pushed, then inputs are sequenced per cycle.
  // ds/dl: rdy low for dl cycles starting at relative cycle ds.
  // stall: io_buffer_full high for cycles 1..stall. clr_at: clear pulse cycle (0 = none).
  task automatic do_req(input bit w, input logic [31:0] a, input logic [2:0] l,
                        input logic [31:0] d, input int ds, input int dl,
                        input int stall, input int clr_at);
    int nb, lat, c0, start, nwr, s;
    logic [63:0] v;
    rsp_t r;
    rd_t q;
    wrx_t x;
    bit got;
    nb = l[1] ? 4 : (l[0] ? 2 : 1);
    @(posedge clk); #1;
    valid = 1'b1; wr = w; addr = a; len = l; data = d;
    c0 = cyc;
    start = resp_cnt;
    if (w) begin
      nwr = nb;
      if (clr_at > 0 && clr_at - 1 < nb) nwr = clr_at - 1;
      for (int k = 0; k < nwr; k++) begin
        x.a = a + k;
        x.d = d[8*k +: 8];
        exp_wr.push_back(x);
        ref_mem[x.a] = x.d;
      end
      lat = nb + 1 + dl + ((nb == 1 && a[17:16] == 2'b11) ? stall : 0);
      r.res = 32'd0;
    end else begin
      v = 64'd0;
      for (int k = 0; k < nb; k++) v = v | (64'(ref_rd(a + k)) << (8 * k));
      if (!l[2] && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      r.res = v[31:0];
      lat = nb + 2 + dl;
      for (s = 1; s <= nb + 1; s++) begin
        q.cyc = c0 + ((dl > 0 && s >= ds) ? s + dl : s);
        q.a = (s <= nb) ? a + s - 1 : 32'd0;
        exp_rd.push_back(q);
      end
    end
    for (int j = 0; j < dl; j++) begin
      q.cyc = c0 + ds + j;
      q.a = 32'd0;
      exp_rd.push_back(q);
    end
    if (clr_at > 0) begin
      q.cyc = c0 + clr_at + 1;
      q.a = 32'd0;
      exp_rd.push_back(q);
    end else begin
      r.c0 = c0;
      r.lat = lat;
      exp_rsp.push_back(r);
    end
    got = 1'b0;
    for (int rel = 1; rel <= 40; rel++) begin
      @(posedge clk); #1;
      if (resp_cnt != start) begin
        got = 1'b1;
        break;
      end
      if (clr_at > 0 && rel > clr_at + 3) break;
      valid = 1'b0;
      rdy = !(dl > 0 && rel >= ds && rel < ds + dl);
      io_buffer_full = (rel <= stall);
      clear = (clr_at > 0 && rel == clr_at);
    end
    valid = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
    if (clr_at == 0 && !got) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: no ready for request at %h, required latency %0d", a, lat);
      exp_rsp.delete();
      exp_rd.delete();
      exp_wr.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rd;
    logic [2:0]  rl;
    bit          rw;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("reset_mem_a", mem_a, 32'd0);
    chk("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
    rst = 1'b1;

    // Byte loads, sign- and zero-extended.
    poke(32'h100, 8'h80);
    do_req(1'b0, 32'h100, 3'b000, 32'd0, 0, 0, 0, 0);
    do_req(1'b0, 32'h100, 3'b100, 32'd0, 0, 0, 0, 0);

    // Word load.
    poke(32'h200, 8'h11); poke(32'h201, 8'h22); poke(32'h202, 8'h33); poke(32'h203, 8'h44);
    do_req(1'b0, 32'h200, 3'b010, 32'd0, 0, 0, 0, 0);
    do_req(1'b0, 32'h200, 3'b011, 32'd0, 0, 0, 0, 0);

    // Misaligned half store and readback.
    do_req(1'b1, 32'h3FF, 3'b001, 32'h0000BEEF, 0, 0, 0, 0);
    do_req(1'b0, 32'h3FF, 3'b001, 32'd0, 0, 0, 0, 0);
    do_req(1'b0, 32'h3FF, 3'b101, 32'd0, 0, 0, 0, 0);

    // IO store stalled by a full buffer, then the same store outside IO.
    do_req(1'b1, 32'h00030000, 3'b000, 32'h41, 0, 0, 3, 0);
    do_req(1'b0, 32'h00030000, 3'b100, 32'd0, 0, 0, 0, 0);
    do_req(1'b1, 32'h00001000, 3'b000, 32'h41, 0, 0, 3, 0);

    // Word load with rdy low for two cycles after C2.
    do_req(1'b0, 32'h200, 3'b010, 32'd0, 3, 2, 0, 0);

    // Clear in C3 of a word store, then a normal request.
    do_req(1'b1, 32'h600, 3'b010, 32'hA1B2C3D4, 0, 0, 0, 3);
    do_req(1'b0, 32'h600, 3'b010, 32'd0, 0, 0, 0, 0);

    // Async reset mid-READ, between edges.
    @(posedge clk); #1;
    valid = 1'b1; wr = 1'b0; addr = 32'h500; len = 3'b010;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_mem_a", mem_a, 32'h501);
    rst = 1'b0;
    #1;
    chk("async_ready", {31'd0, ready}, 32'd0);
    chk("async_res", res, 32'd0);
    chk("async_mem_a", mem_a, 32'd0);
    chk("async_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("async_mem_dout", {24'd0, mem_dout}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    do_req(1'b0, 32'h100, 3'b000, 32'd0, 0, 0, 0, 0);

    // Randomized mix of loads and stores with occasional rdy drops.
    for (int t = 0; t < 60; t++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        2: ra = 32'h00030000 | 32'($urandom_range(0, 255));
        default: ra = 32'($urandom_range(0, 1023));
      endcase
      rl = 3'($urandom_range(0, 7));
      rd = $urandom;
      do_req(rw, ra, rl, rd, $urandom_range(1, 2), $urandom_range(0, 2), 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queues_empty", 32'(exp_rsp.size() + exp_rd.size() + exp_wr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
